// File: rtl/sdr_cmd_pkg.sv
// rtl/sdr_cmd_pkg.sv - shared constants and FSM encoding for the host command receiver
// Contents: command codes, header length, receiver state encoding.
package sdr_cmd_pkg;

  localparam logic [7:0] CMD_DISCOVERY = 8'd2;
  localparam logic [7:0] CMD_SET_IP    = 8'd3;
  localparam logic [7:0] CMD_ERASE     = 8'd4;
  localparam logic [7:0] CMD_PROGRAM   = 8'd5;
  localparam logic [7:0] CMD_PLL_PHASE = 8'd6;
  localparam logic [7:0] CMD_SKEW      = 8'd7;

  // Sequence number (4 bytes) plus command byte.
  localparam int CMD_HDR_LEN = 5;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_HDR    = 3'd1;
  localparam state_t ST_PAY    = 3'd2;
  localparam state_t ST_SKIP   = 3'd3;
  localparam state_t ST_COMMIT = 3'd4;

endpackage

// File: rtl/sdr_cmd_stage.sv
// rtl/sdr_cmd_stage.sv - payload staging buffer with write index and truncation flag
// Ports: clk_i, reset_i (sync, active-high), start_i (clear for a new packet),
//        wr_en_i/wr_data_i (payload byte), data_o (byte 0 in [7:0]), len_o, trunc_o.
module sdr_cmd_stage #(
  parameter  int MAX_PAYLOAD = 16,
  localparam int LW          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  output logic [8*MAX_PAYLOAD-1:0] data_o,
  output logic [LW-1:0]            len_o,
  output logic                     trunc_o
);

  logic [8*MAX_PAYLOAD-1:0] data_q;
  logic [LW-1:0]            len_q;
  logic                     trunc_q;
  logic                     full;

  assign full = (len_q == LW'(MAX_PAYLOAD));

  // Clearing on start keeps unused payload bytes at zero for the consumer.
  always_ff @(posedge clk_i) begin
    if (reset_i || start_i) begin
      data_q  <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else if (wr_en_i) begin
      if (full) begin
        trunc_q <= 1'b1;
      end else begin
        data_q[8*len_q +: 8] <= wr_data_i;
        len_q                <= len_q + LW'(1);
      end
    end
  end

  assign data_o  = data_q;
  assign len_o   = len_q;
  assign trunc_o = trunc_q;

endmodule

// File: rtl/sdr_cmd_rx.sv
// rtl/sdr_cmd_rx.sv - UDP host command receiver with admission, back-pressure and sequence checking
// Ports: rx_clock, reset (sync, active-high); udp_rx_data/udp_rx_active/to_port/broadcast from
//        the UDP receiver; cmd_valid/cmd_ready handshake with cmd_code/cmd_seq/cmd_len/
//        cmd_payload/cmd_truncated; seq_error pulse; drop_count.
// Build option: SDR_CMD_SEQ_CHECK_EN enables sequence-gap detection (seq_error tied low otherwise).
module sdr_cmd_rx
  import sdr_cmd_pkg::*;
#(
  parameter  int          CMD_PORT    = 1024,
  parameter  int          MAX_PAYLOAD = 16,
  parameter  logic [15:0] UCAST_MASK  = 16'h00FC,
  parameter  logic [15:0] BCAST_MASK  = 16'h000C,
  localparam int          LW          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                     rx_clock,
  input  logic                     reset,
  input  logic [7:0]               udp_rx_data,
  input  logic                     udp_rx_active,
  input  logic [15:0]              to_port,
  input  logic                     broadcast,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_code,
  output logic [31:0]              cmd_seq,
  output logic [LW-1:0]            cmd_len,
  output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
  output logic                     cmd_truncated,
  output logic                     seq_error,
  output logic [15:0]              drop_count
);

  state_t state_q, state_d;
  logic [2:0]  idx_q;
  logic [31:0] seq_q;
  logic [7:0]  code_q;
  logic        bcast_q;

  logic                     valid_q;
  logic [7:0]               out_code_q;
  logic [31:0]              out_seq_q;
  logic [LW-1:0]            out_len_q;
  logic [8*MAX_PAYLOAD-1:0] out_payload_q;
  logic                     out_trunc_q;
  logic [15:0]              drop_q;

  logic                     start, port_hit, wr_en;
  logic                     mask_bit, admit, blocked, load, drop;
  logic [8*MAX_PAYLOAD-1:0] stg_data;
  logic [LW-1:0]            stg_len;
  logic                     stg_trunc;

  // COMMIT behaves like IDLE for byte 0 so a single idle cycle between packets suffices.
  assign start    = udp_rx_active && (state_q == ST_IDLE || state_q == ST_COMMIT);
  assign port_hit = (to_port == 16'(CMD_PORT));
  assign wr_en    = udp_rx_active && (state_q == ST_PAY);

  sdr_cmd_stage #(.MAX_PAYLOAD(MAX_PAYLOAD)) u_stage (
    .clk_i     (rx_clock),
    .reset_i   (reset),
    .start_i   (start),
    .wr_en_i   (wr_en),
    .wr_data_i (udp_rx_data),
    .data_o    (stg_data),
    .len_o     (stg_len),
    .trunc_o   (stg_trunc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_COMMIT: begin
        if (udp_rx_active) state_d = port_hit ? ST_HDR : ST_SKIP;
        else               state_d = ST_IDLE;
      end
      ST_HDR: begin
        if (!udp_rx_active)                     state_d = ST_COMMIT;
        else if (idx_q == 3'(CMD_HDR_LEN - 1))  state_d = ST_PAY;
      end
      ST_PAY:  if (!udp_rx_active) state_d = ST_COMMIT;
      ST_SKIP: if (!udp_rx_active) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A runt falls out of HDR before idx reaches the full header length.
  assign mask_bit = bcast_q ? BCAST_MASK[code_q[3:0]] : UCAST_MASK[code_q[3:0]];
  assign admit    = (state_q == ST_COMMIT) && (idx_q == 3'(CMD_HDR_LEN)) &&
                    (code_q < 8'd16) && mask_bit;
  assign blocked  = valid_q && !cmd_ready;
  assign load     = admit && !blocked;
  assign drop     = admit && blocked;

  always_ff @(posedge rx_clock) begin
    if (reset) begin
      // Entering SKIP when reset lands mid-packet abandons the rest of that packet.
      state_q <= udp_rx_active ? ST_SKIP : ST_IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      code_q  <= '0;
      bcast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        idx_q   <= 3'd1;
        seq_q   <= {24'd0, udp_rx_data};
        bcast_q <= broadcast;
      end else if (state_q == ST_HDR && udp_rx_active) begin
        if (idx_q == 3'(CMD_HDR_LEN - 1)) code_q <= udp_rx_data;
        else                              seq_q  <= {seq_q[23:0], udp_rx_data};
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge rx_clock) begin
    if (reset) begin
      valid_q       <= 1'b0;
      out_code_q    <= '0;
      out_seq_q     <= '0;
      out_len_q     <= '0;
      out_payload_q <= '0;
      out_trunc_q   <= 1'b0;
      drop_q        <= '0;
    end else begin
      if (load) begin
        valid_q       <= 1'b1;
        out_code_q    <= code_q;
        out_seq_q     <= seq_q;
        out_len_q     <= stg_len;
        out_payload_q <= stg_data;
        out_trunc_q   <= stg_trunc;
      end else if (cmd_ready) begin
        valid_q <= 1'b0;
      end
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

`ifdef SDR_CMD_SEQ_CHECK_EN
  logic [31:0] expected_q;
  logic        first_q;
  logic        seq_err_q;

  // Dropped commands still advance the expected sequence number.
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      expected_q <= '0;
      first_q    <= 1'b1;
      seq_err_q  <= 1'b0;
    end else begin
      seq_err_q <= 1'b0;
      if (admit) begin
        seq_err_q  <= !first_q && (seq_q != expected_q);
        expected_q <= seq_q + 32'd1;
        first_q    <= 1'b0;
      end
    end
  end

  assign seq_error = seq_err_q;
`else
  assign seq_error = 1'b0;
`endif

  assign cmd_valid     = valid_q;
  assign cmd_code      = out_code_q;
  assign cmd_seq       = out_seq_q;
  assign cmd_len       = out_len_q;
  assign cmd_payload   = out_payload_q;
  assign cmd_truncated = out_trunc_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_sdr_cmd_rx.sv
// tb/tb_sdr_cmd_rx.sv - directed self-checking bench for sdr_cmd_rx
module tb_sdr_cmd_rx;

`ifdef SDR_CMD_SEQ_CHECK_EN
  localparam logic SEQ_EN = 1'b1;
`else
  localparam logic SEQ_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [7:0]   udp_rx_data;
  logic         udp_rx_active;
  logic [15:0]  to_port;
  logic         broadcast;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_code;
  logic [31:0]  cmd_seq;
  logic [4:0]   cmd_len;
  logic [127:0] cmd_payload;
  logic         cmd_truncated;
  logic         seq_error;
  logic [15:0]  drop_count;

  int checks = 0;
  int passed = 0;

  logic [7:0] pkt [0:31];
  int         plen;

  sdr_cmd_rx dut (
    .rx_clock      (clk),
    .reset         (reset),
    .udp_rx_data   (udp_rx_data),
    .udp_rx_active (udp_rx_active),
    .to_port       (to_port),
    .broadcast     (broadcast),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_code      (cmd_code),
    .cmd_seq       (cmd_seq),
    .cmd_len       (cmd_len),
    .cmd_payload   (cmd_payload),
    .cmd_truncated (cmd_truncated),
    .seq_error     (seq_error),
    .drop_count    (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic build(input logic [31:0] seq, input logic [7:0] code,
                       input int npay, input logic [7:0] first);
    pkt[0] = seq[31:24];
    pkt[1] = seq[23:16];
    pkt[2] = seq[15:8];
    pkt[3] = seq[7:0];
    pkt[4] = code;
    for (int i = 0; i < npay; i++) pkt[5+i] = first + 8'(i);
    plen = 5 + npay;
  endtask

  // to_port/broadcast are scrambled after byte 0 to show they are ignored mid-packet.
  task automatic send(input logic [15:0] port, input logic bc);
    for (int i = 0; i < plen; i++) begin
      @(negedge clk);
      udp_rx_active = 1'b1;
      udp_rx_data   = pkt[i];
      to_port       = (i == 0) ? port : 16'h0000;
      broadcast     = (i == 0) ? bc : ~bc;
    end
    @(negedge clk);
    udp_rx_active = 1'b0;
    udp_rx_data   = 8'h00;
  endtask

  task automatic wait_commit;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; udp_rx_data = 8'h00; udp_rx_active = 1'b0;
    to_port = 16'd0; broadcast = 1'b0; cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_valid", cmd_valid, 0);
    chk("reset_code", cmd_code, 0);
    chk("reset_len", cmd_len, 0);
    chk("reset_drop", drop_count, 0);
    chk("reset_seqerr", seq_error, 0);

    // Unicast cmd 6, payload 05 01; exact latency checked.
    build(32'h0000_0010, 8'd6, 2, 8'h05);
    pkt[6] = 8'h01;
    send(16'd1024, 1'b0);
    @(negedge clk);
    chk("t1_valid_early", cmd_valid, 0);
    @(negedge clk);
    chk("t1_valid", cmd_valid, 1);
    chk("t1_code", cmd_code, 8'd6);
    chk("t1_seq", cmd_seq, 32'h10);
    chk("t1_len", cmd_len, 5'd2);
    chk("t1_payload", cmd_payload, 128'h0105);
    chk("t1_trunc", cmd_truncated, 0);
    chk("t1_seqerr", seq_error, 0);
    @(negedge clk);
    chk("t1_valid_drop", cmd_valid, 0);

    // Sequence gap 0x10 -> 0x12.
    build(32'h0000_0012, 8'd6, 1, 8'hAA);
    send(16'd1024, 1'b0);
    wait_commit;
    chk("t2_valid", cmd_valid, 1);
    chk("t2_seq", cmd_seq, 32'h12);
    chk("t2_seqerr", seq_error, SEQ_EN);
    @(negedge clk);
    chk("t2_seqerr_once", seq_error, 0);

    build(32'h0000_0013, 8'd6, 1, 8'hAA);
    send(16'd1024, 1'b0);
    wait_commit;
    chk("t3_valid", cmd_valid, 1);
    chk("t3_seqerr", seq_error, 0);

    // Wrap 0xFFFFFFFF -> 0.
    build(32'hFFFF_FFFF, 8'd6, 0, 8'h00);
    send(16'd1024, 1'b0);
    wait_commit;
    chk("t4a_seq", cmd_seq, 32'hFFFF_FFFF);
    build(32'h0000_0000, 8'd7, 0, 8'h00);
    send(16'd1024, 1'b0);
    wait_commit;
    chk("t4b_valid", cmd_valid, 1);
    chk("t4b_code", cmd_code, 8'd7);
    chk("t4b_seqerr", seq_error, 0);

    // Broadcast: cmd 4 refused, cmd 2 admitted.
    build(32'h0000_0001, 8'd4, 1, 8'h11);
    send(16'd1024, 1'b1);
    wait_commit;
    chk("t5_bcast4_valid", cmd_valid, 0);
    chk("t5_bcast4_code", cmd_code, 8'd7);
    build(32'h0000_0001, 8'd2, 1, 8'h22);
    send(16'd1024, 1'b1);
    wait_commit;
    chk("t6_bcast2_valid", cmd_valid, 1);
    chk("t6_bcast2_code", cmd_code, 8'd2);
    chk("t6_bcast2_seqerr", seq_error, 0);

    // Wrong port.
    build(32'h0000_0002, 8'd6, 1, 8'h33);
    send(16'd1025, 1'b0);
    wait_commit;
    chk("t7_port_valid", cmd_valid, 0);
    chk("t7_port_code", cmd_code, 8'd2);

    // Back-pressure: first held, next two (back-to-back) dropped.
    cmd_ready = 1'b0;
    build(32'h0000_0002, 8'd3, 1, 8'h40);
    send(16'd1024, 1'b0);
    wait_commit;
    chk("bp1_valid", cmd_valid, 1);
    chk("bp1_code", cmd_code, 8'd3);
    build(32'h0000_0003, 8'd5, 1, 8'h50);
    send(16'd1024, 1'b0);
    build(32'h0000_0004, 8'd7, 1, 8'h60);
    send(16'd1024, 1'b0);
    wait_commit;
    chk("bp_drop2", drop_count, 16'd2);
    chk("bp_hold_code", cmd_code, 8'd3);
    chk("bp_hold_seq", cmd_seq, 32'h2);
    chk("bp_hold_valid", cmd_valid, 1);

    // Ready rises in the commit cycle of a fourth packet.
    build(32'h0000_0005, 8'd4, 1, 8'h70);
    send(16'd1024, 1'b0);
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("bp4_valid", cmd_valid, 1);
    chk("bp4_code", cmd_code, 8'd4);
    chk("bp4_seq", cmd_seq, 32'h5);
    chk("bp4_drop", drop_count, 16'd2);
    @(negedge clk);
    chk("bp4_valid_clear", cmd_valid, 0);

    // Truncation with 20 payload bytes.
    build(32'h0000_0006, 8'd5, 20, 8'h10);
    send(16'd1024, 1'b0);
    wait_commit;
    chk("tr_valid", cmd_valid, 1);
    chk("tr_len", cmd_len, 5'd16);
    chk("tr_trunc", cmd_truncated, 1);
    chk("tr_payload", cmd_payload, 128'h1F1E1D1C1B1A19181716151413121110);

    // Runt: 3 bytes only.
    build(32'h0000_0007, 8'd6, 0, 8'h00);
    plen = 3;
    send(16'd1024, 1'b0);
    wait_commit;
    chk("runt_valid", cmd_valid, 0);
    chk("runt_code", cmd_code, 8'd5);
    chk("runt_len", cmd_len, 5'd16);
    chk("runt_drop", drop_count, 16'd2);

    // Reset during the payload of a packet.
    build(32'h0000_0100, 8'd6, 6, 8'h80);
    for (int i = 0; i < plen; i++) begin
      @(negedge clk);
      udp_rx_active = 1'b1;
      udp_rx_data   = pkt[i];
      to_port       = 16'd1024;
      broadcast     = 1'b0;
      reset         = (i == 7);
    end
    @(negedge clk);
    udp_rx_active = 1'b0;
    wait_commit;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_code", cmd_code, 0);
    chk("rst_drop", drop_count, 0);

    build(32'h0000_0500, 8'd6, 1, 8'h9A);
    send(16'd1024, 1'b0);
    wait_commit;
    chk("post_rst_valid", cmd_valid, 1);
    chk("post_rst_seq", cmd_seq, 32'h500);
    chk("post_rst_payload", cmd_payload, 128'h9A);
    chk("post_rst_seqerr", seq_error, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
